imm_ext_stage: RTL and testbench

IMM_EXT_STAGE -- requirements
Module: imm_ext_stage

---
 rtl/imm_ext_stage.sv | 119 +++++++++++
 tb/tb_imm_ext_stage.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_ext_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imm_ext_stage
// Brief    : Immediate extender feeding a 2-entry skid FIFO with registered head.
// Revision : 1.0
// ============================================================================
module imm_ext_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
);

    localparam int c_PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] r_memData [2];
    logic [1:0]       r_memMode [2];
    logic             r_wrPtr;
    logic             r_rdPtr;
    logic [1:0]       r_count;
    logic [OUT_W-1:0] r_outData;
    logic [1:0]       r_outMode;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_consume;
    logic             w_rdPtrNext;
    logic [1:0]       w_countNext;
    logic [OUT_W-1:0] w_headData;
    logic [1:0]       w_headMode;

    always_comb begin
        w_sext = {{c_PAD_W{in_imm[IN_W-1]}}, in_imm};
        w_ext  = w_sext;
        case (in_mode)
            2'b00:   w_ext = w_sext;
            2'b01:   w_ext = {{c_PAD_W{1'b0}}, in_imm};
            2'b10:   w_ext = {in_imm, {c_PAD_W{1'b0}}};
            default: w_ext = {w_sext[OUT_W-3:0], 2'b00};
        endcase
    end

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_outData;
    assign out_mode  = r_outMode;

    assign w_accept    = in_valid && in_ready && !flush;
    assign w_consume   = out_valid && out_ready && !flush;
    assign w_rdPtrNext = r_rdPtr ^ w_consume;

    always_comb begin
        w_countNext = r_count;
        if (w_accept && !w_consume) begin
            w_countNext = r_count + 2'd1;
        end else if (!w_accept && w_consume) begin
            w_countNext = r_count - 2'd1;
        end
    end

    // Pre-compute the head after this edge so the output port is a plain register;
    // a slot being written this edge must be bypassed from the extender.
    always_comb begin
        w_headData = '0;
        w_headMode = '0;
        if (w_countNext != 2'd0) begin
            if (w_accept && (r_wrPtr == w_rdPtrNext)) begin
                w_headData = w_ext;
                w_headMode = in_mode;
            end else begin
                w_headData = r_memData[w_rdPtrNext];
                w_headMode = r_memMode[w_rdPtrNext];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_memData[r_wrPtr] <= w_ext;
            r_memMode[r_wrPtr] <= in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr   <= 1'b0;
            r_rdPtr   <= 1'b0;
            r_count   <= 2'd0;
            r_outData <= '0;
            r_outMode <= 2'b00;
        end else if (flush) begin
            r_wrPtr   <= 1'b0;
            r_rdPtr   <= 1'b0;
            r_count   <= 2'd0;
            r_outData <= '0;
            r_outMode <= 2'b00;
        end else begin
            r_wrPtr   <= r_wrPtr ^ w_accept;
            r_rdPtr   <= w_rdPtrNext;
            r_count   <= w_countNext;
            r_outData <= w_headData;
            r_outMode <= w_headMode;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_imm_ext_stage
// Brief    : Self-checking bench for imm_ext_stage with a queue reference model.
// Revision : 1.0
// ============================================================================
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_imm = '0;
    logic [1:0]  in_mode = '0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_mode;

    logic        nInValid = 1'b0;
    logic [11:0] nInImm = '0;
    logic [1:0]  nInMode = '0;
    logic        nOutReady = 1'b0;
    logic        nInReady;
    logic        nOutValid;
    logic [15:0] nOutData;
    logic [1:0]  nOutMode;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];

    imm_ext_stage #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    imm_ext_stage #(.IN_W(12), .OUT_W(16)) dutNarrow (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .in_valid(nInValid), .in_ready(nInReady), .in_imm(nInImm), .in_mode(nInMode),
        .out_valid(nOutValid), .out_ready(nOutReady), .out_data(nOutData), .out_mode(nOutMode)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Extension computed arithmetically from the mode rules.
    function automatic logic [31:0] refExt(input logic [15:0] imm, input logic [1:0] mode);
        longint s;
        s = longint'(imm);
        if (imm[15]) s = s - 65536;
        case (mode)
            2'b00:   return 32'(s);
            2'b01:   return 32'(longint'(imm));
            2'b10:   return 32'(longint'(imm) * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    // Advance one clock edge and apply the same transfer to the queue model.
    task automatic tick();
        bit   acc;
        bit   con;
        ent_t e;
        acc = in_valid && (mq.size() < 2) && !flush;
        con = (mq.size() > 0) && out_ready && !flush;
        e.mode = in_mode;
        e.data = refExt(in_imm, in_mode);
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_mode !== 2'b00) begin
            bad++;
            $display("FAIL reset_state: valid=%b ready=%b data=%h mode=%b required 0 1 00000000 00",
                     out_valid, in_ready, out_data, out_mode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_modes();
        logic [31:0] expd [4];
        expd[0] = 32'hFFFF8004;
        expd[1] = 32'h00008004;
        expd[2] = 32'h80040000;
        expd[3] = 32'hFFFE0010;
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1;
            in_imm   = 16'h8004;
            in_mode  = 2'(m);
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== expd[m] || out_mode !== 2'(m)) begin
                bad++;
                $display("FAIL mode_%0d: valid=%b data=%h mode=%b required 1 %h %0d",
                         m, out_valid, out_data, out_mode, expd[m], m);
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL modes_drain: valid=%b data=%h required 0 00000000", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[$];
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b01;
        in_imm    = 16'h0001;
        tick();
        in_imm = 16'h0002;
        tick();
        in_imm = 16'h0003;
        total++;
        if (in_ready !== 1'b0 || out_data !== 32'h1) begin
            bad++;
            $display("FAIL full_stall: in_ready=%b head=%h required 0 00000001", in_ready, out_data);
        end
        tick();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1) begin
            bad++;
            $display("FAIL head_hold: in_ready=%b valid=%b head=%h required 0 1 00000001",
                     in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bit took;
            if (out_valid && out_ready) got.push_back(out_data);
            took = in_valid && in_ready;
            tick();
            if (took) in_valid = 1'b0;
        end
        total++;
        if (got.size() != 3 || got[0] !== 32'h1 || got[1] !== 32'h2 || got[2] !== 32'h3) begin
            bad++;
            $display("FAIL order: got %0d entries first=%h required 3 entries 1,2,3",
                     got.size(), (got.size() > 0) ? got[0] : 32'hx);
        end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_imm    = 16'h0010;
        tick();
        in_imm    = 16'h0020;
        out_ready = 1'b1;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h10 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL simul_pre: valid=%b head=%h ready=%b required 1 00000010 1",
                     out_valid, out_data, in_ready);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h20 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL simul_post: valid=%b head=%h ready=%b required 1 00000020 1",
                     out_valid, out_data, in_ready);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL simul_count: valid=%b required 0 (count was not 1)", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b01;
        in_imm    = 16'h00AA;
        tick();
        in_imm = 16'h00BB;
        tick();
        in_imm    = 16'h00CC;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL flush: valid=%b ready=%b data=%h required 0 1 00000000",
                     out_valid, in_ready, out_data);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_nothing_taken: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_imm    = 16'h1111;
        tick();
        in_imm = 16'h2222;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL async_reset: valid=%b ready=%b data=%h required 0 1 00000000",
                     out_valid, in_ready, out_data);
        end
        #1;
        rst_n = 1'b1;
        mq.delete();
        in_valid  = 1'b1;
        in_imm    = 16'h7FFF;
        in_mode   = 2'b11;
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h0001FFFC || out_mode !== 2'b11) begin
            bad++;
            $display("FAIL post_reset_branch: valid=%b data=%h mode=%b required 1 0001fffc 11",
                     out_valid, out_data, out_mode);
        end
        in_valid = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_ghost: valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_random();
        ent_t h;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 30) == 0);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            tick();
            h = (mq.size() > 0) ? mq[0] : '0;
            total++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
                out_data !== h.data || out_mode !== h.mode) begin
                bad++;
                $display("FAIL random_%0d: valid=%b ready=%b data=%h mode=%b required %b %b %h %b",
                         i, out_valid, in_ready, out_data, out_mode,
                         (mq.size() > 0), (mq.size() < 2), h.data, h.mode);
            end
        end
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_narrow();
        nInValid  = 1'b1;
        nInImm    = 12'h800;
        nInMode   = 2'b00;
        nOutReady = 1'b1;
        @(posedge clk);
        #1;
        nInValid = 1'b0;
        total++;
        if (nOutValid !== 1'b1 || nOutData !== 16'hF800 || nOutMode !== 2'b00) begin
            bad++;
            $display("FAIL narrow_sign: valid=%b data=%h mode=%b required 1 f800 00",
                     nOutValid, nOutData, nOutMode);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        test_narrow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
